lcd_bus_receiver: RTL and testbench
===================================

Name: lcd_bus_receiver

Overview:
- Synthesizable receiver and checker for the 4-bit LCD write interface: the LCD end of the nibble bus driven by the LCD power-on init and command logic.
- Decodes the power-on sequence 0x3, 0x3, 0x3, 0x2, then assembles high/low nibble pairs into bytes with their RS value.
- Checks E pulse width and inter-edge timing; flags protocol errors.
- Used as the loopback/checker stage in the LCD controller datapath.

Parameters:
- E_MIN_HIGH, 12: minimum LCD_E high width, in cycles.
- T_POWERON, 750000: minimum cycles from reset release (or from init restart) to the first init nibble.
- T_INIT1, 205000: minimum gap before the 2nd 0x3.
- T_INIT2, 5000: minimum gap before the 3rd 0x3.
- T_INIT3, 2000: minimum gap before 0x2, and before the first command high nibble.
- T_NIB, 50: minimum gap from the high-nibble edge to the low-nibble edge.
- T_BYTE, 2000: minimum gap from a byte's low-nibble edge to the next high-nibble edge.
- T_CLR, 82000: the T_BYTE replacement after command byte 0x01 or 0x02.

Ports:
- clk, input, 1: clock, rising edge.
- reset, input, 1: asynchronous, active-low; asserted when 0.
- LCD_E, input, 1: bus strobe. Synchronous to clk; no synchronizer.
- LCD_RS, input, 1: register select.
- LCD_RW, input, 1: read/write (1 = read).
- SF_D, input, 4: data nibble (bus bits 11:8).
- init_done, output, 1: sticky; set when the init sequence completes.
- byte_valid, output, 1: one-cycle pulse when a byte is assembled.
- byte_out, output, 8: assembled byte, high nibble first.
- rs_out, output, 1: RS captured with the high nibble.
- err_width, output, 1: one-cycle pulse on an E pulse shorter than E_MIN_HIGH.
- err_timing, output, 1: one-cycle pulse on a gap violation.
- err_init, output, 1: one-cycle pulse on a wrong init nibble or early init edge.
- err_proto, output, 1: one-cycle pulse on RW=1, or on an RS mismatch between the nibbles of a byte.

Behaviour:

Reset:
- Every output is 0 and the state is INIT0.
- Gap counter = 0, width counter = 0, e_q = 0.
- Reset asserted mid-byte or mid-init discards all partial data and returns to INIT0.

Edge detection:
- e_q is LCD_E registered.
- fall = e_q & ~LCD_E.
- SF_D, LCD_RS and LCD_RW are latched every cycle in which LCD_E=1. The fall event uses these latched values.

Counters:
- Width counter: counts while LCD_E=1, clears while LCD_E=0, saturates at 2^8-1.
- Gap counter: 20 bits, increments every cycle, saturates at 2^20-1. It clears on the cycle after each accepted or rejected fall, and on an init restart.

Latency:
- Every output pulse and register update is visible exactly 1 cycle after the cycle in which fall is detected.

Fall with width < E_MIN_HIGH:
- Pulse err_width, discard the nibble, leave the state unchanged, and still clear the gap counter.

Fall with latched RW=1:
- Pulse err_proto, discard the nibble, leave the state unchanged.

State machine (checks apply on each valid fall):
- INIT0: expect 0x3 with gap >= T_POWERON, then go to INIT1.
- INIT1: expect 0x3 with gap >= T_INIT1, then go to INIT2.
- INIT2: expect 0x3 with gap >= T_INIT2, then go to INIT3.
- INIT3: expect 0x2 with gap >= T_INIT3, then set init_done and go to HI. The required gap for the next HI is T_INIT3.
- Any init mismatch (wrong value or gap too short): pulse err_init and go to INIT0. T_POWERON is then re-measured from that edge.
- HI: capture the high nibble and RS, then go to LO. If gap < required gap, pulse err_timing; the nibble is still accepted.
- LO: if gap < T_NIB, pulse err_timing; data is still accepted.
  - If the latched RS differs from the captured RS, pulse err_proto and set rs_out to the high-nibble RS.
  - Drive byte_out = {hi, lo}, pulse byte_valid, go to HI.
  - Required next gap = T_CLR if RS=0 and the byte is 0x01 or 0x02; otherwise T_BYTE.

Other rules:
- Multiple errors on the same fall pulse all applicable flags in the same cycle.
- byte_out and rs_out hold their value between bytes.
- init_done never clears except on reset.
- A gap exactly equal to its minimum passes.

Test Plan:
1. Init pass: release reset, then send 0x3 @750000, 0x3 @+205000, 0x3 @+5000, 0x2 @+2000, each with E high 12 cycles. Required: init_done=1 one cycle after the 4th fall; no error pulses.
2. Early init edge: 2nd 0x3 at gap 204999. Required: err_init pulse; state INIT0. A full sequence sent afterwards from that edge then completes normally.
3. Byte assembly: after init, send RS=1 nibbles 0x4 then 0x1 (gap 50), with the high nibble at gap 2000. Required: byte_valid pulse, byte_out=0x41, rs_out=1.
4. Clear timing: send command 0x01 (RS=0), then the next high nibble at gap 81999. Required: err_timing pulse; byte still assembled. Repeating with gap 82000 produces no error.
5. Short E: pulse E 11 cycles with nibble 0x5 in HI. Required: err_width pulse; state stays HI; no byte_valid.
6. Protocol errors: an E pulse with RW=1 gives err_proto and is discarded. A high nibble with RS=0 followed by a low nibble with RS=1 gives err_proto, byte_valid, and rs_out=0. Reset asserted between the nibbles clears all outputs and returns to INIT0.

Source files
------------

// File: rtl/lcd_bus_receiver.sv
// LCD-side receiver/checker for the 4-bit write bus: decodes the power-on init
// nibbles, assembles command/data bytes and flags strobe, timing and protocol errors.
//
// state | meaning
// ------+------------------------------------------------------------
// INIT0 | waiting for first 0x3 after power-on (or after an init error)
// INIT1 | waiting for second 0x3
// INIT2 | waiting for third 0x3
// INIT3 | waiting for 0x2 (switch to 4-bit mode)
// HI    | waiting for the high nibble of a byte
// LO    | waiting for the low nibble of a byte
module lcd_bus_receiver #(
   parameter int unsigned E_MIN_HIGH = 12,
   parameter int unsigned T_POWERON  = 750000,
   parameter int unsigned T_INIT1    = 205000,
   parameter int unsigned T_INIT2    = 5000,
   parameter int unsigned T_INIT3    = 2000,
   parameter int unsigned T_NIB      = 50,
   parameter int unsigned T_BYTE     = 2000,
   parameter int unsigned T_CLR      = 82000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       LCD_E,
   input  logic       LCD_RS,
   input  logic       LCD_RW,
   input  logic [3:0] SF_D,
   output logic       init_done,
   output logic       byte_valid,
   output logic [7:0] byte_out,
   output logic       rs_out,
   output logic       err_width,
   output logic       err_timing,
   output logic       err_init,
   output logic       err_proto
);

   typedef enum logic [2:0] {
      S_INIT0,
      S_INIT1,
      S_INIT2,
      S_INIT3,
      S_HI,
      S_LO
   } state_t;

   localparam logic [19:0] GAP_MAX = '1;
   localparam logic [7:0]  W_MAX   = '1;
   localparam logic [7:0]  W_MIN   = 8'(E_MIN_HIGH);
   localparam logic [19:0] G_PON   = 20'(T_POWERON);
   localparam logic [19:0] G_INIT1 = 20'(T_INIT1);
   localparam logic [19:0] G_INIT2 = 20'(T_INIT2);
   localparam logic [19:0] G_INIT3 = 20'(T_INIT3);
   localparam logic [19:0] G_NIB   = 20'(T_NIB);
   localparam logic [19:0] G_BYTE  = 20'(T_BYTE);
   localparam logic [19:0] G_CLR   = 20'(T_CLR);

   state_t      state, state_nx;
   logic        e_q;
   logic        fall;
   logic [3:0]  d_lat;
   logic        rs_lat, rw_lat;
   logic [7:0]  width_cnt;
   logic [19:0] gap_cnt;
   logic [19:0] req_gap, req_gap_nx;
   logic [3:0]  hi_nib, hi_nib_nx;
   logic        hi_rs, hi_rs_nx;
   logic [7:0]  byte_asm;
   logic        width_bad;

   logic        init_done_nx, byte_valid_nx, rs_out_nx;
   logic [7:0]  byte_out_nx;
   logic        err_width_nx, err_timing_nx, err_init_nx, err_proto_nx;

   assign fall      = e_q & ~LCD_E;
   assign byte_asm  = {hi_nib, d_lat};
   assign width_bad = (width_cnt < W_MIN);

   always_comb begin
      state_nx      = state;
      req_gap_nx    = req_gap;
      hi_nib_nx     = hi_nib;
      hi_rs_nx      = hi_rs;
      init_done_nx  = init_done;
      byte_out_nx   = byte_out;
      rs_out_nx     = rs_out;
      byte_valid_nx = 1'b0;
      err_width_nx  = 1'b0;
      err_timing_nx = 1'b0;
      err_init_nx   = 1'b0;
      err_proto_nx  = 1'b0;

      if (fall) begin
         err_width_nx = width_bad;
         err_proto_nx = rw_lat;
         // A short strobe or a read cycle carries no usable nibble.
         if (!width_bad && !rw_lat) begin
            case (state)
               S_INIT0: begin
                  if (d_lat == 4'h3 && gap_cnt >= G_PON) state_nx = S_INIT1;
                  else err_init_nx = 1'b1;
               end
               S_INIT1: begin
                  if (d_lat == 4'h3 && gap_cnt >= G_INIT1) state_nx = S_INIT2;
                  else begin
                     err_init_nx = 1'b1;
                     state_nx    = S_INIT0;
                  end
               end
               S_INIT2: begin
                  if (d_lat == 4'h3 && gap_cnt >= G_INIT2) state_nx = S_INIT3;
                  else begin
                     err_init_nx = 1'b1;
                     state_nx    = S_INIT0;
                  end
               end
               S_INIT3: begin
                  if (d_lat == 4'h2 && gap_cnt >= G_INIT3) begin
                     state_nx     = S_HI;
                     init_done_nx = 1'b1;
                     req_gap_nx   = G_INIT3;
                  end else begin
                     err_init_nx = 1'b1;
                     state_nx    = S_INIT0;
                  end
               end
               S_HI: begin
                  err_timing_nx = (gap_cnt < req_gap);
                  hi_nib_nx     = d_lat;
                  hi_rs_nx      = rs_lat;
                  state_nx      = S_LO;
               end
               S_LO: begin
                  err_timing_nx = (gap_cnt < G_NIB);
                  err_proto_nx  = (rs_lat != hi_rs);
                  byte_out_nx   = byte_asm;
                  rs_out_nx     = hi_rs;
                  byte_valid_nx = 1'b1;
                  state_nx      = S_HI;
                  // Clear display / return home need the long settle time.
                  if (!hi_rs && (byte_asm == 8'h01 || byte_asm == 8'h02)) req_gap_nx = G_CLR;
                  else req_gap_nx = G_BYTE;
               end
               default: state_nx = S_INIT0;
            endcase
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= S_INIT0;
         e_q        <= 1'b0;
         d_lat      <= 4'h0;
         rs_lat     <= 1'b0;
         rw_lat     <= 1'b0;
         width_cnt  <= 8'd0;
         gap_cnt    <= 20'd0;
         req_gap    <= 20'd0;
         hi_nib     <= 4'h0;
         hi_rs      <= 1'b0;
         init_done  <= 1'b0;
         byte_valid <= 1'b0;
         byte_out   <= 8'h00;
         rs_out     <= 1'b0;
         err_width  <= 1'b0;
         err_timing <= 1'b0;
         err_init   <= 1'b0;
         err_proto  <= 1'b0;
      end else begin
         e_q <= LCD_E;
         if (LCD_E) begin
            d_lat  <= SF_D;
            rs_lat <= LCD_RS;
            rw_lat <= LCD_RW;
         end
         if (!LCD_E) width_cnt <= 8'd0;
         else if (width_cnt != W_MAX) width_cnt <= width_cnt + 8'd1;
         if (fall) gap_cnt <= 20'd0;
         else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 20'd1;

         state      <= state_nx;
         req_gap    <= req_gap_nx;
         hi_nib     <= hi_nib_nx;
         hi_rs      <= hi_rs_nx;
         init_done  <= init_done_nx;
         byte_valid <= byte_valid_nx;
         byte_out   <= byte_out_nx;
         rs_out     <= rs_out_nx;
         err_width  <= err_width_nx;
         err_timing <= err_timing_nx;
         err_init   <= err_init_nx;
         err_proto  <= err_proto_nx;
      end
   end

endmodule

// File: tb/tb_lcd_bus_receiver.sv
// Directed bench for lcd_bus_receiver with shortened timing parameters; each
// nibble is placed so its fall lands at an exact gap-counter value.
module tb_lcd_bus_receiver;

   localparam int E_MIN   = 12;
   localparam int T_PON   = 600;
   localparam int T_I1    = 300;
   localparam int T_I2    = 200;
   localparam int T_I3    = 100;
   localparam int T_NIBB  = 50;
   localparam int T_BYT   = 120;
   localparam int T_CLRR  = 400;

   logic       clk = 1'b0;
   logic       reset;
   logic       LCD_E, LCD_RS, LCD_RW;
   logic [3:0] SF_D;
   logic       init_done, byte_valid, rs_out;
   logic [7:0] byte_out;
   logic       err_width, err_timing, err_init, err_proto;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int ref_cyc = 0;

   // pulse vector order: {byte_valid, err_width, err_timing, err_init, err_proto}
   logic [4:0] o_pulse, o_early;
   logic       o_done, o_rs, o_early_done;
   logic [7:0] o_byte;

   lcd_bus_receiver #(
      .E_MIN_HIGH(E_MIN), .T_POWERON(T_PON), .T_INIT1(T_I1), .T_INIT2(T_I2),
      .T_INIT3(T_I3), .T_NIB(T_NIBB), .T_BYTE(T_BYT), .T_CLR(T_CLRR)
   ) dut (
      .clk(clk), .reset(reset), .LCD_E(LCD_E), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
      .SF_D(SF_D), .init_done(init_done), .byte_valid(byte_valid), .byte_out(byte_out),
      .rs_out(rs_out), .err_width(err_width), .err_timing(err_timing),
      .err_init(err_init), .err_proto(err_proto)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic goto_cyc(input int n);
      while (cyc < n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Fall is placed at gap counter value 'gap' measured from ref_cyc; outputs
   // are sampled one cycle later, and also in the fall cycle itself.
   task automatic send(input logic [3:0] nib, input logic rs, input logic rw,
                       input int width, input int gap);
      int fall_c;
      fall_c = ref_cyc + gap;
      goto_cyc(fall_c - width);
      LCD_E = 1'b1; SF_D = nib; LCD_RS = rs; LCD_RW = rw;
      goto_cyc(fall_c);
      LCD_E = 1'b0; SF_D = 4'h0; LCD_RS = 1'b0; LCD_RW = 1'b0;
      #1;
      o_early      = {byte_valid, err_width, err_timing, err_init, err_proto};
      o_early_done = init_done;
      goto_cyc(fall_c + 1);
      ref_cyc = fall_c + 1;
      o_pulse = {byte_valid, err_width, err_timing, err_init, err_proto};
      o_done  = init_done;
      o_rs    = rs_out;
      o_byte  = byte_out;
   endtask

   task automatic test_reset;
      reset = 1'b0;
      LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0; SF_D = 4'h0;
      goto_cyc(cyc + 3);
      checks++;
      if ({init_done, byte_valid, byte_out, rs_out, err_width, err_timing, err_init, err_proto} !== 15'd0) begin
         failures++;
         $display("FAIL reset_outputs got=%b exp=0", {init_done, byte_valid, byte_out, rs_out,
                  err_width, err_timing, err_init, err_proto});
      end
      reset = 1'b1;
      ref_cyc = cyc;
   endtask

   task automatic init_seq(input string tag);
      logic [3:0] nibs [4];
      int         gaps [4];
      nibs = '{4'h3, 4'h3, 4'h3, 4'h2};
      gaps = '{T_PON, T_I1, T_I2, T_I3};
      for (int i = 0; i < 4; i++) begin
         send(nibs[i], 1'b0, 1'b0, E_MIN, gaps[i]);
         checks++;
         if (o_pulse !== 5'b00000) begin
            failures++;
            $display("FAIL %s_pulses step=%0d got=%b exp=00000", tag, i, o_pulse);
         end
         checks++;
         if (o_done !== (i == 3)) begin
            failures++;
            $display("FAIL %s_init_done step=%0d got=%b exp=%b", tag, i, o_done, (i == 3));
         end
      end
      checks++;
      if ({o_early_done, o_early} !== 6'b0) begin
         failures++;
         $display("FAIL %s_latency got=%b exp=000000", tag, {o_early_done, o_early});
      end
   endtask

   task automatic test_init_pass;
      test_reset();
      init_seq("init_pass");
   endtask

   task automatic test_early_init;
      test_reset();
      send(4'h3, 1'b0, 1'b0, E_MIN, T_PON);
      send(4'h3, 1'b0, 1'b0, E_MIN, T_I1 - 1);
      checks++;
      if (o_pulse !== 5'b00010) begin
         failures++;
         $display("FAIL early_init_err got=%b exp=00010", o_pulse);
      end
      init_seq("reinit");
   endtask

   task automatic test_byte;
      send(4'h4, 1'b1, 1'b0, E_MIN, T_I3);
      checks++;
      if (o_pulse !== 5'b00000) begin
         failures++;
         $display("FAIL byte_hi_pulses got=%b exp=00000", o_pulse);
      end
      send(4'h1, 1'b1, 1'b0, E_MIN, T_NIBB);
      checks++;
      if ({o_pulse, o_byte, o_rs} !== {5'b10000, 8'h41, 1'b1}) begin
         failures++;
         $display("FAIL byte_41 got=%b/%h/%b exp=10000/41/1", o_pulse, o_byte, o_rs);
      end
      goto_cyc(cyc + 1);
      checks++;
      if (byte_valid !== 1'b0) begin
         failures++;
         $display("FAIL byte_valid_one_cycle got=%b exp=0", byte_valid);
      end
   endtask

   task automatic test_clear;
      send(4'h0, 1'b0, 1'b0, E_MIN, T_BYT);
      send(4'h1, 1'b0, 1'b0, E_MIN, T_NIBB);
      checks++;
      if ({o_pulse, o_byte, o_rs} !== {5'b10000, 8'h01, 1'b0}) begin
         failures++;
         $display("FAIL clr_byte_01 got=%b/%h/%b exp=10000/01/0", o_pulse, o_byte, o_rs);
      end
      send(4'h3, 1'b1, 1'b0, E_MIN, T_CLRR - 1);
      checks++;
      if (o_pulse !== 5'b00100) begin
         failures++;
         $display("FAIL clr_gap_short got=%b exp=00100", o_pulse);
      end
      send(4'h8, 1'b1, 1'b0, E_MIN, T_NIBB);
      checks++;
      if ({o_pulse, o_byte, o_rs} !== {5'b10000, 8'h38, 1'b1}) begin
         failures++;
         $display("FAIL clr_byte_38 got=%b/%h/%b exp=10000/38/1", o_pulse, o_byte, o_rs);
      end
      send(4'h0, 1'b0, 1'b0, E_MIN, T_BYT);
      send(4'h2, 1'b0, 1'b0, E_MIN, T_NIBB);
      send(4'h4, 1'b1, 1'b0, E_MIN, T_CLRR);
      checks++;
      if (o_pulse !== 5'b00000) begin
         failures++;
         $display("FAIL clr_gap_exact got=%b exp=00000", o_pulse);
      end
      send(4'h2, 1'b1, 1'b0, E_MIN, T_NIBB - 1);
      checks++;
      if ({o_pulse, o_byte, o_rs} !== {5'b10100, 8'h42, 1'b1}) begin
         failures++;
         $display("FAIL nib_gap_short got=%b/%h/%b exp=10100/42/1", o_pulse, o_byte, o_rs);
      end
   endtask

   task automatic test_short_e;
      send(4'h5, 1'b1, 1'b0, E_MIN - 1, T_BYT);
      checks++;
      if ({o_pulse, o_byte} !== {5'b01000, 8'h42}) begin
         failures++;
         $display("FAIL short_e got=%b/%h exp=01000/42", o_pulse, o_byte);
      end
      send(4'h6, 1'b1, 1'b0, E_MIN, T_BYT);
      send(4'h7, 1'b1, 1'b0, E_MIN, T_NIBB);
      checks++;
      if ({o_pulse, o_byte, o_rs} !== {5'b10000, 8'h67, 1'b1}) begin
         failures++;
         $display("FAIL short_e_state_hi got=%b/%h/%b exp=10000/67/1", o_pulse, o_byte, o_rs);
      end
   endtask

   task automatic test_proto;
      send(4'h9, 1'b1, 1'b1, E_MIN, T_BYT);
      checks++;
      if ({o_pulse, o_byte} !== {5'b00001, 8'h67}) begin
         failures++;
         $display("FAIL rw_read got=%b/%h exp=00001/67", o_pulse, o_byte);
      end
      send(4'h9, 1'b1, 1'b1, E_MIN - 1, T_BYT);
      checks++;
      if (o_pulse !== 5'b01001) begin
         failures++;
         $display("FAIL multi_err got=%b exp=01001", o_pulse);
      end
      send(4'h3, 1'b0, 1'b0, E_MIN, T_BYT);
      send(4'h8, 1'b1, 1'b0, E_MIN, T_NIBB);
      checks++;
      if ({o_pulse, o_byte, o_rs} !== {5'b10001, 8'h38, 1'b0}) begin
         failures++;
         $display("FAIL rs_mismatch got=%b/%h/%b exp=10001/38/0", o_pulse, o_byte, o_rs);
      end
      send(4'h5, 1'b1, 1'b0, E_MIN, T_BYT);
      reset = 1'b0;
      #1;
      checks++;
      if ({init_done, byte_valid, byte_out, rs_out, err_width, err_timing, err_init, err_proto} !== 15'd0) begin
         failures++;
         $display("FAIL midbyte_reset got=%b exp=0", {init_done, byte_valid, byte_out, rs_out,
                  err_width, err_timing, err_init, err_proto});
      end
      goto_cyc(cyc + 3);
      reset = 1'b1;
      ref_cyc = cyc;
      init_seq("post_reset");
      send(4'hA, 1'b1, 1'b0, E_MIN, T_I3);
      send(4'hB, 1'b1, 1'b0, E_MIN, T_NIBB);
      checks++;
      if ({o_pulse, o_byte, o_rs} !== {5'b10000, 8'hAB, 1'b1}) begin
         failures++;
         $display("FAIL post_reset_byte got=%b/%h/%b exp=10000/ab/1", o_pulse, o_byte, o_rs);
      end
   endtask

   initial begin
      reset = 1'b0;
      LCD_E = 1'b0; LCD_RS = 1'b0; LCD_RW = 1'b0; SF_D = 4'h0;
      test_init_pass();
      test_byte();
      test_clear();
      test_short_e();
      test_proto();
      test_early_init();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
